// File: rtl/xband_tx_if.sv
// Link-side bundle for the Xband TX scheduler: two byte-stream requesters,
// the encoder-facing character output, and status counters.
interface xband_tx_if;
  logic        enable;

  logic [7:0]  img_tdata;
  logic        img_tvalid;
  logic        img_tlast;
  logic        img_tready;

  logic [7:0]  tlm_tdata;
  logic        tlm_tvalid;
  logic        tlm_tlast;
  logic        tlm_tready;

  logic [7:0]  txdata;
  logic        txctrl;
  logic        busy;
  logic [15:0] img_pkt_cnt;
  logic [15:0] underrun_cnt;

  // Sources and link consumer side.
  modport master (
    output enable,
    output img_tdata, img_tvalid, img_tlast,
    input  img_tready,
    output tlm_tdata, tlm_tvalid, tlm_tlast,
    input  tlm_tready,
    input  txdata, txctrl, busy, img_pkt_cnt, underrun_cnt
  );

  // Scheduler side.
  modport slave (
    input  enable,
    input  img_tdata, img_tvalid, img_tlast,
    output img_tready,
    input  tlm_tdata, tlm_tvalid, tlm_tlast,
    output tlm_tready,
    output txdata, txctrl, busy, img_pkt_cnt, underrun_cnt
  );
endinterface

// File: rtl/xband_tx_scheduler.sv
// Link-layer scheduler feeding the 8b10b encoder one character per tx_clk:
// round-robin packet arbitration, K-code framing, idle fill and forced commas.
module xband_tx_scheduler #(
  parameter int unsigned COMMA_PERIOD = 64,
  parameter int unsigned MIN_GAP      = 2,
  parameter logic [7:0]  K_IDLE       = 8'hBC,
  parameter logic [7:0]  K_SOF        = 8'hFB,
  parameter logic [7:0]  K_SOT        = 8'h5C,
  parameter logic [7:0]  K_EOF        = 8'hFD
) (
  input  logic       tx_clk,
  input  logic       tx_rst_n,
  xband_tx_if.slave  bus
);

  localparam int RUN_W = $clog2(COMMA_PERIOD + 1);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_DATA,
    S_EOF,
    S_GAP
  } state_t;

  state_t           r_state;
  logic             r_grant_tlm;
  logic             r_last_tlm;
  logic [RUN_W-1:0] r_run_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [7:0]       r_txdata;
  logic             r_txctrl;
  logic             r_busy;
  logic [15:0]      r_img_pkt_cnt;
  logic [15:0]      r_underrun_cnt;

  logic             w_comma_due;
  logic             w_in_data;
  logic             w_pick_tlm;
  logic             w_g_valid;
  logic             w_g_last;
  logic [7:0]       w_g_data;

  assign w_comma_due = (r_run_cnt == RUN_W'(COMMA_PERIOD));
  assign w_in_data   = (r_state == S_DATA);

  // tready depends only on state and run count so a source may wait for it.
  assign bus.img_tready = w_in_data && !r_grant_tlm && !w_comma_due;
  assign bus.tlm_tready = w_in_data &&  r_grant_tlm && !w_comma_due;

  // Tie goes to whichever source was not granted last.
  assign w_pick_tlm = bus.tlm_tvalid && (!bus.img_tvalid || !r_last_tlm);

  assign w_g_valid = r_grant_tlm ? bus.tlm_tvalid : bus.img_tvalid;
  assign w_g_last  = r_grant_tlm ? bus.tlm_tlast  : bus.img_tlast;
  assign w_g_data  = r_grant_tlm ? bus.tlm_tdata  : bus.img_tdata;

  assign bus.txdata       = r_txdata;
  assign bus.txctrl       = r_txctrl;
  assign bus.busy         = r_busy;
  assign bus.img_pkt_cnt  = r_img_pkt_cnt;
  assign bus.underrun_cnt = r_underrun_cnt;

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch reads the pre-edge values; blocking would chain updates in one edge.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      r_state        <= S_IDLE;
      r_grant_tlm    <= 1'b0;
      r_last_tlm     <= 1'b1;
      r_run_cnt      <= '0;
      r_gap_cnt      <= '0;
      r_txdata       <= K_IDLE;
      r_txctrl       <= 1'b1;
      r_busy         <= 1'b0;
      r_img_pkt_cnt  <= '0;
      r_underrun_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txdata <= K_IDLE;
          r_txctrl <= 1'b1;
          if (bus.enable && (bus.img_tvalid || bus.tlm_tvalid)) begin
            r_grant_tlm <= w_pick_tlm;
            r_last_tlm  <= w_pick_tlm;
            r_state     <= S_SOF;
            r_busy      <= 1'b1;
          end
        end

        S_SOF: begin
          r_txdata  <= r_grant_tlm ? K_SOT : K_SOF;
          r_txctrl  <= 1'b1;
          r_run_cnt <= '0;
          r_state   <= S_DATA;
        end

        S_DATA: begin
          if (w_comma_due) begin
            r_txdata  <= K_IDLE;
            r_txctrl  <= 1'b1;
            r_run_cnt <= '0;
          end else if (w_g_valid) begin
            r_txdata  <= w_g_data;
            r_txctrl  <= 1'b0;
            r_run_cnt <= r_run_cnt + RUN_W'(1);
            if (w_g_last) r_state <= S_EOF;
          end else begin
            // Source starved: fill with a comma, which also restarts the run.
            r_txdata  <= K_IDLE;
            r_txctrl  <= 1'b1;
            r_run_cnt <= '0;
            if (r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
          end
        end

        S_EOF: begin
          r_txdata  <= K_EOF;
          r_txctrl  <= 1'b1;
          r_gap_cnt <= '0;
          r_state   <= S_GAP;
          if (!r_grant_tlm) r_img_pkt_cnt <= r_img_pkt_cnt + 16'd1;
        end

        S_GAP: begin
          r_txdata  <= K_IDLE;
          r_txctrl  <= 1'b1;
          r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          if (r_gap_cnt == GAP_W'(MIN_GAP - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_txdata <= K_IDLE;
          r_txctrl <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xband_tx_scheduler.sv
// Directed bench for xband_tx_scheduler: recorded character streams are compared
// against hand-built expected sequences, plus counters and reset behaviour.
module tb_xband_tx_scheduler;

  logic clk;
  logic rst_n;

  xband_tx_if bus ();

  xband_tx_scheduler #(
    .COMMA_PERIOD (4),
    .MIN_GAP      (2)
  ) u_dut (
    .tx_clk   (clk),
    .tx_rst_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Source queue entry: {bubble, last, data}; a bubble holds tvalid low one cycle.
  logic [9:0] img_q[$];
  logic [9:0] tlm_q[$];
  logic [8:0] rec_q[$];
  logic       rdy_q[$];
  logic [8:0] exp_q[$];
  bit         img_adv;
  bit         tlm_adv;
  bit         rec_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: sample outputs on the falling edge, then update source drive.
  task automatic tick();
    @(negedge clk);
    if (rec_en) begin
      rec_q.push_back({bus.txctrl, bus.txdata});
      rdy_q.push_back(bus.img_tready | bus.tlm_tready);
    end
    if (img_adv && img_q.size() > 0) void'(img_q.pop_front());
    if (tlm_adv && tlm_q.size() > 0) void'(tlm_q.pop_front());
    if (img_q.size() > 0 && !img_q[0][9]) begin
      bus.img_tvalid = 1'b1;
      bus.img_tlast  = img_q[0][8];
      bus.img_tdata  = img_q[0][7:0];
    end else begin
      bus.img_tvalid = 1'b0;
      bus.img_tlast  = 1'b0;
      bus.img_tdata  = 8'h00;
    end
    if (tlm_q.size() > 0 && !tlm_q[0][9]) begin
      bus.tlm_tvalid = 1'b1;
      bus.tlm_tlast  = tlm_q[0][8];
      bus.tlm_tdata  = tlm_q[0][7:0];
    end else begin
      bus.tlm_tvalid = 1'b0;
      bus.tlm_tlast  = 1'b0;
      bus.tlm_tdata  = 8'h00;
    end
    img_adv = (img_q.size() > 0) && (img_q[0][9] || bus.img_tready);
    tlm_adv = (tlm_q.size() > 0) && (tlm_q[0][9] || bus.tlm_tready);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.enable = 1'b1;
    img_q.delete();
    tlm_q.delete();
    img_adv = 0;
    tlm_adv = 0;
    rec_en  = 0;
    bus.img_tvalid = 1'b0; bus.img_tlast = 1'b0; bus.img_tdata = 8'h00;
    bus.tlm_tvalid = 1'b0; bus.tlm_tlast = 1'b0; bus.tlm_tdata = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // First tick presents the queued data; recording starts with the grant-cycle char.
  task automatic start_rec();
    rec_q.delete();
    rdy_q.delete();
    tick();
    rec_en = 1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
    rec_en = 0;
  endtask

  task automatic push_k(input logic [7:0] c);
    exp_q.push_back({1'b1, c});
  endtask

  task automatic push_d(input logic [7:0] d);
    exp_q.push_back({1'b0, d});
  endtask

  task automatic check_stream(input string tag, input bit with_rdy);
    check({tag, ".len"}, rec_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), {23'd0, rec_q[i]}, {23'd0, exp_q[i]});
      if (with_rdy && i + 1 < exp_q.size())
        check($sformatf("%s.rdy[%0d]", tag, i), {31'd0, rdy_q[i]}, {31'd0, !exp_q[i+1][8]});
    end
  endtask

  initial begin
    bus.enable = 1'b1;
    rst_n = 1'b1;
    do_reset();

    // 1: idle link emits K28.5 with no requesters
    check("rst.busy", bus.busy, 1'b0);
    check("rst.img_cnt", bus.img_pkt_cnt, 16'd0);
    check("rst.und_cnt", bus.underrun_cnt, 16'd0);
    rec_q.delete(); rdy_q.delete(); exp_q.delete();
    rec_en = 1;
    run(8);
    for (int i = 0; i < 8; i++) push_k(8'hBC);
    check_stream("idle", 1);

    // 2: single 4-byte image packet
    exp_q.delete();
    for (int i = 1; i <= 4; i++) img_q.push_back({1'b0, (i == 4), 8'(i)});
    start_rec();
    tick();
    check("pkt.busy", bus.busy, 1'b1);
    run(8);
    push_k(8'hBC); push_k(8'hFB);
    for (int i = 1; i <= 4; i++) push_d(8'(i));
    push_k(8'hFD); push_k(8'hBC); push_k(8'hBC);
    check_stream("img4", 1);
    check("img4.cnt", bus.img_pkt_cnt, 16'd1);

    // 3: both sources always valid, 1-byte packets alternate starting with image
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      img_q.push_back({1'b0, 1'b1, 8'(8'hA1 + i)});
      tlm_q.push_back({1'b0, 1'b1, 8'(8'hC1 + i)});
    end
    push_k(8'hBC);
    for (int p = 0; p < 4; p++) begin
      push_k((p % 2 == 0) ? 8'hFB : 8'h5C);
      push_d((p % 2 == 0) ? 8'(8'hA1 + p / 2) : 8'(8'hC1 + p / 2));
      push_k(8'hFD); push_k(8'hBC); push_k(8'hBC);
      if (p < 3) push_k(8'hBC);
    end
    start_rec();
    run(exp_q.size());
    check_stream("rr", 1);
    check("rr.cnt", bus.img_pkt_cnt, 16'd2);

    // 4: forced comma every COMMA_PERIOD=4 data chars in a 10-byte packet
    repeat (2) tick();
    exp_q.delete();
    for (int i = 0; i < 10; i++) img_q.push_back({1'b0, (i == 9), 8'(8'h20 + i)});
    push_k(8'hBC); push_k(8'hFB);
    for (int i = 0; i < 10; i++) begin
      push_d(8'(8'h20 + i));
      if (i == 3 || i == 7) push_k(8'hBC);
    end
    push_k(8'hFD); push_k(8'hBC); push_k(8'hBC);
    start_rec();
    run(exp_q.size());
    check_stream("comma", 1);
    check("comma.cnt", bus.img_pkt_cnt, 16'd3);
    check("comma.und", bus.underrun_cnt, 16'd0);

    // 5: three-cycle tvalid drop mid-packet
    do_reset();
    exp_q.delete();
    img_q.push_back({1'b0, 1'b0, 8'h11});
    img_q.push_back({1'b0, 1'b0, 8'h12});
    for (int i = 0; i < 3; i++) img_q.push_back(10'h200);
    for (int i = 0; i < 4; i++) img_q.push_back({1'b0, (i == 3), 8'(8'h13 + i)});
    push_k(8'hBC); push_k(8'hFB); push_d(8'h11); push_d(8'h12);
    push_k(8'hBC); push_k(8'hBC); push_k(8'hBC);
    for (int i = 0; i < 4; i++) push_d(8'(8'h13 + i));
    push_k(8'hFD); push_k(8'hBC); push_k(8'hBC);
    start_rec();
    run(exp_q.size());
    check_stream("under", 0);
    check("under.cnt", bus.underrun_cnt, 16'd3);
    check("under.pkts", bus.img_pkt_cnt, 16'd1);

    // 6: reset mid-DATA abandons the packet; next packet starts cleanly
    exp_q.delete();
    for (int i = 0; i < 8; i++) img_q.push_back({1'b0, (i == 7), 8'(8'h30 + i)});
    push_k(8'hBC); push_k(8'hFB); push_d(8'h30); push_d(8'h31);
    start_rec();
    run(4);
    check_stream("pre_rst", 0);
    #10 rst_n = 1'b0;
    #1;
    check("rst.txdata", bus.txdata, 8'hBC);
    check("rst.txctrl", bus.txctrl, 1'b1);
    check("rst.img_rdy", bus.img_tready, 1'b0);
    check("rst.busy2", bus.busy, 1'b0);
    check("rst.cnt2", bus.img_pkt_cnt, 16'd0);
    img_q.delete();
    img_adv = 0;
    bus.img_tvalid = 1'b0; bus.img_tlast = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) push_k(8'hBC);
    rec_q.delete(); rdy_q.delete();
    rec_en = 1;
    run(6);
    check_stream("post_rst", 1);

    // enable low holds off grants; raising it starts the pending packet
    bus.enable = 1'b0;
    img_q.push_back({1'b0, 1'b1, 8'h40});
    repeat (6) tick();
    check("dis.busy", bus.busy, 1'b0);
    check("dis.txdata", bus.txdata, 8'hBC);
    exp_q.delete();
    push_k(8'hBC); push_k(8'hFB); push_d(8'h40); push_k(8'hFD); push_k(8'hBC);
    rec_q.delete(); rdy_q.delete();
    rec_en = 1;
    bus.enable = 1'b1;
    run(5);
    check_stream("restart", 1);
    check("restart.cnt", bus.img_pkt_cnt, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
